// File: rtl/adc_lvds_pkg.sv
package adc_lvds_pkg;

  localparam int unsigned DEF_SAMPLE_WIDTH = 12;
  localparam int unsigned DEF_LANES        = 2;

  typedef enum logic [1:0] {
    TM_DATA = 2'b00,
    TM_RAMP = 2'b01,
    TM_IDLE = 2'b10,
    TM_ALT  = 2'b11
  } test_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/adc_lvds_frame_generator_word_source.sv
module adc_lvds_word_source
  import adc_lvds_pkg::*;
#(
  parameter int unsigned             SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter logic [SAMPLE_WIDTH-1:0] IDLE_WORD    = 12'h800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    load,
  input  logic                    restart,
  output logic [SAMPLE_WIDTH-1:0] word,
  output logic                    underrun
);

  test_mode_e                mode_e;
  logic [SAMPLE_WIDTH-1:0]   hold_word;
  logic                      hold_full;
  logic                      hold_full_nxt;
  logic [SAMPLE_WIDTH-1:0]   ramp;
  logic                      alt_sel;
  logic [SAMPLE_WIDTH-1:0]   alt_a;
  logic                      accept;
  logic                      consume;

  assign mode_e = test_mode_e'(mode);

  // 0xAAA-style pattern stretched or cut to the sample width: bit i = i mod 2.
  always_comb begin
    alt_a = '0;
    for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
      alt_a[i] = i[0];
    end
  end

  always_comb begin
    word     = IDLE_WORD;
    underrun = 1'b0;
    case (mode_e)
      TM_DATA: begin
        word     = hold_full ? hold_word : IDLE_WORD;
        underrun = load && !hold_full;
      end
      TM_RAMP: word = ramp;
      TM_IDLE: word = IDLE_WORD;
      TM_ALT:  word = alt_sel ? ~alt_a : alt_a;
      default: word = IDLE_WORD;
    endcase
  end

  assign accept        = sample_valid && sample_ready;
  assign consume       = load && (mode_e == TM_DATA) && hold_full;
  assign hold_full_nxt = (hold_full && !consume) || accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_word    <= '0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b0;
      ramp         <= '0;
      alt_sel      <= 1'b0;
    end else begin
      hold_full    <= hold_full_nxt;
      sample_ready <= !hold_full_nxt;
      if (accept) begin
        hold_word <= sample;
      end
      if (load && (mode_e == TM_RAMP)) begin
        ramp <= ramp + SAMPLE_WIDTH'(1);
      end
      if (restart) begin
        alt_sel <= 1'b0;
      end else if (load && (mode_e == TM_ALT)) begin
        alt_sel <= !alt_sel;
      end
    end
  end

endmodule

// File: rtl/adc_lvds_frame_generator.sv
module adc_lvds_frame_generator
  import adc_lvds_pkg::*;
#(
  parameter int unsigned             SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
  parameter int unsigned             LANES           = DEF_LANES,
  parameter int unsigned             PREAMBLE_FRAMES = 4,
  parameter logic [SAMPLE_WIDTH-1:0] IDLE_WORD       = 12'h800
) (
  input  logic                    i_lvds_bitClk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [1:0]              i_testMode,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_sampleValid,
  output logic                    o_sampleReady,
  input  logic                    i_clrUnderrun,
  output logic                    o_frameClk,
  output logic [LANES-1:0]        o_data,
  output logic                    o_frameStart,
  output logic                    o_underrun,
  output logic [15:0]             o_frameCount
);

  localparam int unsigned FRAME_LEN = SAMPLE_WIDTH / LANES;
  localparam int unsigned PHASE_W   = $clog2(FRAME_LEN);
  localparam int unsigned PRE_W     = (PREAMBLE_FRAMES > 1) ? $clog2(PREAMBLE_FRAMES) : 1;

  localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(FRAME_LEN - 1);
  localparam logic [PHASE_W-1:0] PH_HALF  = PHASE_W'(FRAME_LEN / 2);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PREAMBLE_FRAMES - 1);

  if (((SAMPLE_WIDTH % LANES) != 0) || (FRAME_LEN < 4) || ((FRAME_LEN % 2) != 0) ||
      (PREAMBLE_FRAMES < 1)) begin : g_param_check
    $error("adc_lvds_frame_generator: SAMPLE_WIDTH/LANES must be an even integer >= 4 and PREAMBLE_FRAMES >= 1");
  end

  state_e                  state;
  state_e                  nxt_state;
  logic [PHASE_W-1:0]      phase;
  logic [PHASE_W-1:0]      nxt_phase;
  logic [PRE_W-1:0]        pre_cnt;
  logic [PRE_W-1:0]        nxt_pre;
  logic [SAMPLE_WIDTH-1:0] shift_word;
  logic [SAMPLE_WIDTH-1:0] nxt_word;
  logic [LANES-1:0]        nxt_data;
  logic                    stop_req;
  logic                    stop;
  logic                    last_phase;
  logic                    load;
  logic                    sync_entry;
  logic                    active_nxt;
  logic [SAMPLE_WIDTH-1:0] src_word;
  logic                    src_underrun;

  adc_lvds_word_source #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .IDLE_WORD    (IDLE_WORD)
  ) u_word_source (
    .clk          (i_lvds_bitClk),
    .rst_n        (i_rst_n),
    .mode         (i_testMode),
    .sample       (i_sample),
    .sample_valid (i_sampleValid),
    .sample_ready (o_sampleReady),
    .load         (load),
    .restart      (sync_entry),
    .word         (src_word),
    .underrun     (src_underrun)
  );

  always_comb begin
    nxt_state  = state;
    nxt_phase  = phase;
    nxt_pre    = pre_cnt;
    nxt_word   = shift_word;
    load       = 1'b0;
    sync_entry = 1'b0;
    stop       = stop_req || !i_enable;
    last_phase = (phase == PH_LAST);
    case (state)
      ST_IDLE: begin
        if (i_enable) begin
          nxt_state  = ST_SYNC;
          nxt_phase  = '0;
          nxt_pre    = '0;
          nxt_word   = IDLE_WORD;
          sync_entry = 1'b1;
        end
      end
      ST_SYNC: begin
        nxt_phase = last_phase ? '0 : phase + PHASE_W'(1);
        if (last_phase) begin
          if (stop) begin
            nxt_state = ST_IDLE;
          end else if (pre_cnt == PRE_LAST) begin
            nxt_state = ST_RUN;
            load      = 1'b1;
            nxt_word  = src_word;
          end else begin
            nxt_pre  = pre_cnt + PRE_W'(1);
            nxt_word = IDLE_WORD;
          end
        end
      end
      ST_RUN: begin
        nxt_phase = last_phase ? '0 : phase + PHASE_W'(1);
        if (last_phase) begin
          if (stop) begin
            nxt_state = ST_IDLE;
          end else begin
            load     = 1'b1;
            nxt_word = src_word;
          end
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_phase = '0;
      end
    endcase
  end

  assign active_nxt = (nxt_state != ST_IDLE);

  // Outputs are registered from the next-cycle phase/word so they line up with the phase they describe.
  always_comb begin
    nxt_data = '0;
    for (int unsigned p = 0; p < FRAME_LEN; p++) begin
      if (nxt_phase == PHASE_W'(p)) begin
        nxt_data = nxt_word[p*LANES +: LANES];
      end
    end
  end

  always_ff @(posedge i_lvds_bitClk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      phase        <= '0;
      pre_cnt      <= '0;
      shift_word   <= '0;
      stop_req     <= 1'b0;
      o_frameClk   <= 1'b0;
      o_data       <= '0;
      o_frameStart <= 1'b0;
      o_underrun   <= 1'b0;
      o_frameCount <= '0;
    end else begin
      state      <= nxt_state;
      phase      <= nxt_phase;
      pre_cnt    <= nxt_pre;
      shift_word <= nxt_word;
      // A disable seen anywhere in the frame is latched so the frame still ends in IDLE.
      stop_req   <= (nxt_state == ST_IDLE) ? 1'b0
                  : (stop_req || ((state != ST_IDLE) && !i_enable));

      o_frameClk   <= active_nxt && (nxt_phase < PH_HALF);
      o_data       <= active_nxt ? nxt_data : '0;
      o_frameStart <= active_nxt && (nxt_phase == '0);

      if (src_underrun) begin
        o_underrun <= 1'b1;
      end else if (i_clrUnderrun) begin
        o_underrun <= 1'b0;
      end

      if (sync_entry) begin
        o_frameCount <= '0;
      end else if (active_nxt && (nxt_phase == '0)) begin
        o_frameCount <= o_frameCount + 16'd1;
      end
    end
  end

endmodule

// File: doc/adc_lvds_frame_generator.md
Name: adc_lvds_frame_generator

Overview:
- Transmit-side counterpart of the ADC LVDS capture path. Serialises parallel sample words into a frame clock plus data lanes with the same framing the ADC produces: LSB first, frame clock high for the first half of each frame.
- Used for FPGA loopback, board bring-up and closed-loop verification of the capture/FFT chain without a physical ADC.
- Sits between a sample source (pattern generator or DMA) and the LVDS output buffers, clocked at bit rate.

Parameters:
- SAMPLE_WIDTH, 12, bits per sample word.
- LANES, 2, data lanes. SAMPLE_WIDTH/LANES must be an even integer >= 4.
- PREAMBLE_FRAMES, 4, frames of frame clock with IDLE_WORD data sent before live data after enable.
- IDLE_WORD, 12'h800, word sent during preamble and on underrun (mid-scale).

Ports:
- i_lvds_bitClk  in  1  bit-rate clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous reset, active low.
- i_enable  in  1  run request; level sensitive.
- i_testMode  in  2  word source: 00 input data, 01 ramp, 10 IDLE_WORD constant, 11 alternating 0xAAA/0x555 (truncated/extended to SAMPLE_WIDTH).
- i_sample  in  SAMPLE_WIDTH  input sample word.
- i_sampleValid  in  1  i_sample valid.
- o_sampleReady  out  1  holding register empty; a transfer occurs when valid && ready.
- i_clrUnderrun  in  1  synchronous clear of o_underrun.
- o_frameClk  out  1  emulated ADC frame clock.
- o_data  out  LANES  serial data lanes.
- o_frameStart  out  1  one-cycle pulse coincident with phase 0 of every frame.
- o_underrun  out  1  sticky flag: a data-mode frame boundary found the holding register empty.
- o_frameCount  out  16  frames sent since leaving IDLE; wraps at 0xFFFF->0.

Behaviour:
- FRAME_LEN = SAMPLE_WIDTH/LANES cycles per frame. The phase counter runs 0..FRAME_LEN-1 and wraps.
- Reset (asynchronous, i_rst_n=0): state IDLE, phase 0, all outputs 0, o_sampleReady 0, holding register empty, ramp 0. Reset asserted mid-frame aborts the frame immediately.
- Output timing: all outputs are registered. o_frameClk=1 for phases 0..FRAME_LEN/2-1 and 0 otherwise. o_data[l] = shiftWord[p*LANES+l] at phase p.
- IDLE state:
  - o_frameClk=0, o_data=0, o_frameStart=0.
  - o_sampleReady = holding empty.
  - i_enable=1 -> SYNC, starting phase 0 on the next cycle. IDLE lasts at least one cycle, so the receiver sees a low frame clock before the first high.
- SYNC state:
  - Sends PREAMBLE_FRAMES frames of IDLE_WORD, regardless of i_testMode.
  - After the last phase of the last preamble frame -> RUN.
- RUN state, at phase FRAME_LEN-1, the next word is loaded into shiftWord so it is visible at phase 0:
  - Mode 00, holding full: load the holding word and mark it empty.
  - Mode 00, holding empty: load IDLE_WORD and set o_underrun.
  - Mode 01: load the ramp value, then ramp+1, wrapping at 2^SAMPLE_WIDTH.
  - Mode 10: load IDLE_WORD.
  - Mode 11: load the alternating pattern; the first word after SYNC is 0xAAA.
  - Input is accepted in every state, including IDLE and SYNC.
- Handshake:
  - 1-deep holding register; o_sampleReady = !holdFull, registered.
  - Simultaneous accept and consume at the boundary cycle: the consume empties the holding register and the accept refills it in the same cycle; o_sampleReady stays 0.
  - Latency: a word accepted during frame N appears starting at phase 0 of frame N+1.
- Disable: i_enable=0 during SYNC or RUN completes the current frame, then enters IDLE. The holding register is retained, not flushed.
- o_frameStart and o_frameCount: both update at phase 0 in SYNC and RUN. o_frameCount clears on entry to SYNC.
- Underrun clear: if i_clrUnderrun and a new underrun occur in the same cycle, set wins.
- Parameter check: an invalid parameter combination is a elaboration-time error.

Decomposition:
- Package adc_lvds_pkg:
  - test-mode encodings (TM_DATA, TM_RAMP, TM_IDLE, TM_ALT);
  - state encoding (ST_IDLE, ST_SYNC, ST_RUN);
  - default SAMPLE_WIDTH and LANES, shared with the capture side.
- One sub-module, adc_lvds_word_source: mode mux, ramp/alternate generator, holding register and handshake. It outputs the next word and an underrun pulse.
- The top level keeps the FSM, phase counter and serialiser.

Test Plan:
- Reset mid-RUN (i_rst_n low during phase 2) -> all outputs 0 in the same cycle, no clock edge needed. After release, IDLE with o_frameClk=0.
- Enable, mode 00, feed 0x5A3 -> 4 preamble frames of 0x800 with o_frameStart every 6 cycles. In the first RUN frame, lane0 carries bits 0,2,4,6,8,10 of 0x5A3 and lane1 the odd bits. o_frameClk pattern is 111000.
- Mode 00 with no i_sampleValid in RUN -> frame carries 0x800 and o_underrun=1. Assert i_clrUnderrun -> o_underrun=0 next cycle.
- Mode 01 for 4100 frames -> words 0,1,...,4095,0,... with the wrap checked. o_frameCount increments once per frame.
- Valid held high continuously in mode 00 -> exactly one word accepted per frame, no drops or duplicates. Verify with a scoreboard against the ADC capture sequencer in loopback.
- i_enable dropped at phase 1 -> frame finishes through phase 5, then IDLE. The pending holding word appears in the first RUN frame after re-enable and preamble.
